// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet pool controller: FSM states, default
// pool sizing, aim keycode constants, facing constants and a saturating
// counter helper.
package bullet_pkg;

   // Default pool size and cooldown length
   localparam int DEF_NUM_SLOTS       = 4;
   localparam int DEF_COOLDOWN_FRAMES = 8;

   // Controller FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      COOL = 2'd2
   } ctrlState;

   // Aim keycodes; anything above KEY_8 is treated downstream as default aim
   localparam logic [3:0] KEY_0       = 4'h0;
   localparam logic [3:0] KEY_1       = 4'h1;
   localparam logic [3:0] KEY_2       = 4'h2;
   localparam logic [3:0] KEY_3       = 4'h3;
   localparam logic [3:0] KEY_4       = 4'h4;
   localparam logic [3:0] KEY_5       = 4'h5;
   localparam logic [3:0] KEY_6       = 4'h6;
   localparam logic [3:0] KEY_7       = 4'h7;
   localparam logic [3:0] KEY_8       = 4'h8;
   localparam logic [3:0] KEY_DEFAULT = KEY_0;

   // Player facing
   localparam logic RIGHT = 1'b0;
   localparam logic LEFT  = 1'b1;

   // 8-bit increment that sticks at 255
   function automatic logic [7:0] satInc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_free_picker.sv
// Round-robin free-slot picker: starting at rr_ptr and wrapping around the
// pool, returns the first slot whose active bit is clear.
module rr_free_picker
   import bullet_pkg::*;
#(
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int PTR_W     = 2
) (
   input  logic [NUM_SLOTS-1:0] active,
   input  logic [PTR_W-1:0]     rr_ptr,
   output logic [PTR_W-1:0]     sel,
   output logic                 found
);

   logic [PTR_W-1:0] idx;

   // Scan the pool upward from rr_ptr, keeping the first free slot seen
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         idx = PTR_W'((int'(rr_ptr) + i) % NUM_SLOTS);
         if (!found && !active[idx]) begin
            sel   = idx;
            found = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Bullet pool controller: hands out free bullet slots round-robin while the
// fire button is held, spacing shots by a fixed cooldown, and tracks which
// slots are in flight until the bullet reports that it is done.
module bullet_pool_ctrl
   import bullet_pkg::*;
#(
   parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
   parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
   input  logic                 VS,
   input  logic                 Reset,
   input  logic                 fire_req,
   input  logic [3:0]           keycode,
   input  logic                 direction,
   input  logic [NUM_SLOTS-1:0] slot_done,
   input  logic [NUM_SLOTS-1:0] bullet_on_vec,
   output logic [NUM_SLOTS-1:0] slot_fire,
   output logic [3:0]           fire_keycode,
   output logic                 fire_direction,
   output logic [NUM_SLOTS-1:0] active,
   output logic                 busy_all,
   output logic                 bullet_on,
   output logic [7:0]           shots_fired
);

   localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [PTR_W-1:0]     LAST_IDX = PTR_W'(NUM_SLOTS - 1);
   localparam logic [7:0]           COOL_LOAD = 8'(COOLDOWN_FRAMES - 1);
   localparam logic [NUM_SLOTS-1:0] SLOT0_BIT = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

   ctrlState             state;
   logic [PTR_W-1:0]     rrPtr;
   logic [PTR_W-1:0]     selR;
   logic [7:0]           cnt;

   logic [PTR_W-1:0]     pickSel;
   logic                 pickFound;
   logic [NUM_SLOTS-1:0] activeNext;
   logic [PTR_W-1:0]     ptrNext;

   rr_free_picker #(
      .NUM_SLOTS (NUM_SLOTS),
      .PTR_W     (PTR_W)
   ) uPicker (
      .active (active),
      .rr_ptr (rrPtr),
      .sel    (pickSel),
      .found  (pickFound)
   );

   // Any slot drawing a pixel lights the shared bullet layer
   assign bullet_on = |bullet_on_vec;

   // Next in-flight bitmap: done clears, a launch leaving FIRE sets and wins
   always_comb begin
      activeNext = active & ~slot_done;
      if (state == FIRE) begin
         activeNext = activeNext | (SLOT0_BIT << selR);
      end else begin
         activeNext = activeNext;
      end
   end

   // Round-robin pointer moves to the slot after the one just launched
   always_comb begin
      if (selR == LAST_IDX) begin
         ptrNext = '0;
      end else begin
         ptrNext = selR + PTR_W'(1);
      end
   end

   // Launch FSM with registered launch pulse, latched aim, and pool bookkeeping
   always_ff @(posedge VS) begin
      if (Reset) begin
         state          <= IDLE;
         active         <= '0;
         busy_all       <= 1'b0;
         rrPtr          <= '0;
         selR           <= '0;
         cnt            <= 8'd0;
         shots_fired    <= 8'd0;
         slot_fire      <= '0;
         fire_keycode   <= 4'h0;
         fire_direction <= 1'b0;
      end else begin
         active   <= activeNext;
         busy_all <= &activeNext;
         case (state)
            IDLE: begin
               if (fire_req && pickFound) begin
                  state          <= FIRE;
                  selR           <= pickSel;
                  fire_keycode   <= keycode;
                  fire_direction <= direction;
                  slot_fire      <= SLOT0_BIT << pickSel;
               end else begin
                  slot_fire      <= '0;
               end
            end
            FIRE: begin
               slot_fire   <= '0;
               rrPtr       <= ptrNext;
               shots_fired <= satInc8(shots_fired);
               cnt         <= COOL_LOAD;
               state       <= COOL;
            end
            COOL: begin
               slot_fire <= '0;
               if (cnt == 8'd0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: begin
               slot_fire <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Self-checking bench for bullet_pool_ctrl (NUM_SLOTS=4, COOLDOWN_FRAMES=8):
// directed scenarios with literal expectations plus a randomized run, all
// compared every frame against a frame-level behavioural model.
module tb_bullet_pool_ctrl;

   localparam int N  = 4;
   localparam int CD = 8;

   logic         VS;
   logic         Reset;
   logic         fire_req;
   logic [3:0]   keycode;
   logic         direction;
   logic [N-1:0] slot_done;
   logic [N-1:0] bullet_on_vec;
   logic [N-1:0] slot_fire;
   logic [3:0]   fire_keycode;
   logic         fire_direction;
   logic [N-1:0] active;
   logic         busy_all;
   logic         bullet_on;
   logic [7:0]   shots_fired;

   int tests = 0;
   int fails = 0;
   int frame = 0;

   // behavioural model state
   logic [N-1:0] mActive;
   logic [N-1:0] mSlotFire;
   logic [3:0]   mKey;
   logic         mDir;
   int           mRr;
   int           mShots;
   int           mHold;     // upcoming edges at which fire_req is ignored
   bit           mPend;     // a launched slot becomes active at next edge
   int           mPendSlot;

   bullet_pool_ctrl #(.NUM_SLOTS(N), .COOLDOWN_FRAMES(CD)) dut (
      .VS             (VS),
      .Reset          (Reset),
      .fire_req       (fire_req),
      .keycode        (keycode),
      .direction      (direction),
      .slot_done      (slot_done),
      .bullet_on_vec  (bullet_on_vec),
      .slot_fire      (slot_fire),
      .fire_keycode   (fire_keycode),
      .fire_direction (fire_direction),
      .active         (active),
      .busy_all       (busy_all),
      .bullet_on      (bullet_on),
      .shots_fired    (shots_fired)
   );

   initial begin
      VS = 1'b0;
      forever #5 VS = ~VS;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (frame %0d)", name, act, exp, frame);
      end
   endtask

   function automatic int pickFree();
      int s;
      pickFree = -1;
      for (int i = 0; i < N; i++) begin
         s = (mRr + i) % N;
         if (pickFree < 0 && !mActive[s]) pickFree = s;
      end
   endfunction

   // One frame of the model, using the inputs that the DUT just sampled
   task automatic modelEdge();
      logic [N-1:0] nA;
      int s;
      if (Reset) begin
         mActive = '0; mSlotFire = '0; mKey = 4'h0; mDir = 1'b0;
         mRr = 0; mShots = 0; mHold = 0; mPend = 0; mPendSlot = 0;
      end else begin
         nA = mActive & ~slot_done;
         mSlotFire = '0;
         if (mPend) begin
            nA[mPendSlot] = 1'b1;
            mShots = (mShots < 255) ? mShots + 1 : 255;
            mRr = (mPendSlot + 1) % N;
            mPend = 0;
         end
         if (mHold > 0) begin
            mHold--;
         end else if (fire_req && mActive != {N{1'b1}}) begin
            s = pickFree();
            mSlotFire = '0;
            mSlotFire[s] = 1'b1;
            mKey = keycode;
            mDir = direction;
            mPend = 1;
            mPendSlot = s;
            mHold = CD + 1;
         end
         mActive = nA;
      end
   endtask

   // Advance one frame, update the model, then compare every output
   task automatic step();
      @(posedge VS);
      modelEdge();
      #1;
      frame++;
      check("slot_fire", 32'(slot_fire), 32'(mSlotFire));
      check("active", 32'(active), 32'(mActive));
      check("busy_all", 32'(busy_all), 32'(&mActive));
      check("shots_fired", 32'(shots_fired), 32'(mShots));
      check("fire_keycode", 32'(fire_keycode), 32'(mKey));
      check("fire_direction", 32'(fire_direction), 32'(mDir));
      check("bullet_on", 32'(bullet_on), 32'(|bullet_on_vec));
   endtask

   task automatic doReset();
      Reset = 1'b1; fire_req = 1'b0; slot_done = '0;
      step();
      Reset = 1'b0;
      frame = 0;
   endtask

   initial begin
      logic [N-1:0] d0, d1;
      int nShots;
      Reset = 1'b1; fire_req = 1'b0; keycode = 4'h0; direction = 1'b0;
      slot_done = '0; bullet_on_vec = '0;
      mActive = '0; mSlotFire = '0; mKey = 4'h0; mDir = 1'b0;
      mRr = 0; mShots = 0; mHold = 0; mPend = 0; mPendSlot = 0;

      // reset state
      doReset();
      check("reset_active", 32'(active), 32'h0);
      check("reset_shots", 32'(shots_fired), 32'h0);
      check("reset_fire", 32'(slot_fire), 32'h0);

      // held button: launches at frames 1,11,21,31 then pool full
      fire_req = 1'b1;
      for (int k = 0; k < 45; k++) begin
         step();
         if (frame == 1)  check("hold_f1", 32'(slot_fire), 32'h1);
         if (frame == 11) check("hold_f11", 32'(slot_fire), 32'h2);
         if (frame == 21) check("hold_f21", 32'(slot_fire), 32'h4);
         if (frame == 31) check("hold_f31", 32'(slot_fire), 32'h8);
         if (frame == 32) check("hold_busy", 32'(busy_all), 32'h1);
         if (frame > 31)  check("hold_nopulse", 32'(slot_fire), 32'h0);
      end
      check("hold_shots", 32'(shots_fired), 32'd4);

      // free slot 2 in a full pool; it is picked next
      slot_done = 4'b0100;
      step();
      slot_done = '0;
      step();
      check("refill_slot2", 32'(slot_fire), 32'h4);
      fire_req = 1'b0;
      for (int k = 0; k < 12; k++) step();
      // rr_ptr now 3: free slots 0 and 3, slot 3 goes first
      slot_done = 4'b1001;
      step();
      slot_done = '0;
      fire_req = 1'b1;
      step();
      check("rr_after_slot2", 32'(slot_fire), 32'h8);

      // aim latch holds through later keycode changes
      doReset();
      keycode = 4'h5; direction = 1'b1; fire_req = 1'b1;
      step();
      keycode = 4'h2; direction = 1'b0; fire_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         check("latch_key", 32'(fire_keycode), 32'h5);
         check("latch_dir", 32'(fire_direction), 32'h1);
      end

      // reset during COOL with two slots in flight
      doReset();
      fire_req = 1'b1;
      for (int k = 0; k < 12; k++) step();
      check("pre_reset_active", 32'(active), 32'h3);
      fire_req = 1'b0;
      step();
      Reset = 1'b1; fire_req = 1'b1;
      step();
      check("rst_cool_active", 32'(active), 32'h0);
      check("rst_cool_shots", 32'(shots_fired), 32'h0);
      check("rst_cool_fire", 32'(slot_fire), 32'h0);
      Reset = 1'b0;
      step();
      check("rst_cool_idle", 32'(slot_fire), 32'h1);

      // reset during FIRE: no pulse follows
      doReset();
      fire_req = 1'b1;
      step();
      Reset = 1'b1;
      step();
      check("rst_fire_pulse", 32'(slot_fire), 32'h0);
      Reset = 1'b0; fire_req = 1'b0;
      step();
      check("rst_fire_after", 32'(slot_fire), 32'h0);
      check("rst_fire_active", 32'(active), 32'h0);

      // one-frame press during COOL is dropped
      doReset();
      fire_req = 1'b1;
      step();
      fire_req = 1'b0;
      step(); step();
      fire_req = 1'b1;
      step();
      fire_req = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         check("cool_press", 32'(slot_fire), 32'h0);
      end

      // combinational pixel OR
      bullet_on_vec = 4'b0010;
      #1;
      check("bullet_on_same", 32'(bullet_on), 32'h1);
      bullet_on_vec = '0;
      #1;
      check("bullet_on_zero", 32'(bullet_on), 32'h0);

      // 300 shots with slots retired two frames after launch
      doReset();
      fire_req = 1'b1;
      d0 = '0; d1 = '0; nShots = 0;
      for (int k = 0; k < 3500 && nShots < 300; k++) begin
         slot_done = d1;
         d1 = d0;
         step();
         d0 = slot_fire;
         if (mSlotFire != '0) nShots++;
      end
      check("sat_shot_budget", 32'(nShots), 32'd300);
      check("sat_shots", 32'(shots_fired), 32'd255);
      fire_req = 1'b0; slot_done = '0;

      // randomized run
      for (int k = 0; k < 2500; k++) begin
         Reset = ($urandom_range(0, 99) == 0);
         fire_req = ($urandom_range(0, 3) != 0);
         keycode = 4'($urandom_range(0, 15));
         direction = 1'($urandom_range(0, 1));
         slot_done = N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
         bullet_on_vec = N'($urandom_range(0, 15));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
